// File: rtl/nway_cache.sv
// N-way set-associative read cache with byte-enabled write-through between the
// CPU bus adapter and the SDRAM burst port. Each way owns its tag and data RAM.

module nway_cache_way #(
  parameter int TAG_W      = 16,
  parameter int SET_BITS   = 6,
  parameter int BURST_LOG2 = 2
) (
  input  logic                           clk,
  input  logic [SET_BITS+BURST_LOG2-1:0] rd_idx,
  input  logic [SET_BITS+BURST_LOG2-1:0] wr_idx,
  input  logic                           tag_we,
  input  logic [TAG_W-1:0]               tag_wdata,
  input  logic                           data_we,
  input  logic [1:0]                     data_be,
  input  logic [15:0]                    data_wdata,
  output logic [TAG_W-1:0]               rd_tag,
  output logic [15:0]                    rd_data
);
  localparam int IDX_W = SET_BITS + BURST_LOG2;

  logic [TAG_W-1:0] tag_mem  [2**SET_BITS];
  logic [15:0]      data_mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[wr_idx[IDX_W-1:BURST_LOG2]] <= tag_wdata;
    if (data_we && data_be[1]) data_mem[wr_idx][15:8] <= data_wdata[15:8];
    if (data_we && data_be[0]) data_mem[wr_idx][7:0]  <= data_wdata[7:0];
    rd_tag  <= tag_mem[rd_idx[IDX_W-1:BURST_LOG2]];
    rd_data <= data_mem[rd_idx];
  end
endmodule

module nway_cache #(
  parameter int ADDR_WIDTH = 26,
  parameter int WAYS       = 2,
  parameter int SET_BITS   = 6,
  parameter int BURST_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_req,
  input  logic                  cpu_rw,
  input  logic [1:0]            cpu_bytesel,
  input  logic [15:0]           data_from_cpu,
  output logic                  cpu_ack,
  output logic [15:0]           data_to_cpu,
  input  logic                  flush,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic                  sdram_req,
  output logic                  sdram_rw,
  output logic [1:0]            sdram_bytesel,
  output logic [15:0]           data_to_sdram,
  input  logic [15:0]           data_from_sdram,
  input  logic                  sdram_fill,
  input  logic                  sdram_ack
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int IDX_W = SET_BITS + BURST_LOG2;
  localparam int TAG_W = ADDR_WIDTH - SET_BITS - BURST_LOG2 - 1;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [BURST_LOG2:0] FILL_END = {1'b1, {BURST_LOG2{1'b0}}};

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_RELEASE} state_t;

  state_t                     state;
  logic [SET_BITS-1:0]        init_cnt;
  logic [ADDR_WIDTH-1:1]      addr_r;
  logic                       rw_r, look_ph, fill_on, flush_pend;
  logic [1:0]                 bsel_r;
  logic [15:0]                wdata_r, cap;
  logic [BURST_LOG2:0]        fill_cnt;
  logic [PTR_W-1:0]           victim_r;
  logic [SETS-1:0][WAYS-1:0]  valid;
  logic [SETS-1:0][PTR_W-1:0] rr_ptr;

  logic [WAYS-1:0][TAG_W-1:0] way_tag;
  logic [WAYS-1:0][15:0]      way_data;
  logic [WAYS-1:0]            hit, dwe;
  logic                       hit_any, inv_any, lookup_go, fill_wr, fill_last;
  logic [PTR_W-1:0]           hit_way, inv_way, victim;
  logic [BURST_LOG2-1:0]      fill_idx;
  logic [IDX_W-1:0]           data_idx;
  logic [1:0]                 data_be;
  logic [15:0]                data_wdata;

  logic [SET_BITS-1:0]   set_r;
  logic [BURST_LOG2-1:0] word_r;
  logic [TAG_W-1:0]      tag_r;
  logic                  unused_addr0;
  assign set_r        = addr_r[SET_BITS+BURST_LOG2:BURST_LOG2+1];
  assign word_r       = addr_r[BURST_LOG2:1];
  assign tag_r        = addr_r[ADDR_WIDTH-1:SET_BITS+BURST_LOG2+1];
  assign unused_addr0 = cpu_addr[0];

  // Descending scan so the lowest-index way wins for both hit and invalid pick.
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit[w] = valid[set_r][w] && (way_tag[w] == tag_r);
      if (hit[w]) begin
        hit_any = 1'b1;
        hit_way = PTR_W'(w);
      end
      if (!valid[set_r][w]) begin
        inv_any = 1'b1;
        inv_way = PTR_W'(w);
      end
    end
    victim     = inv_any ? inv_way : rr_ptr[set_r];
    lookup_go  = (state == S_LOOKUP) && look_ph;
    fill_wr    = (state == S_FILL) && (fill_on ? (fill_cnt != FILL_END) : sdram_fill);
    fill_last  = (state == S_FILL) && fill_on && (fill_cnt == FILL_END);
    fill_idx   = fill_on ? fill_cnt[BURST_LOG2-1:0] : '0;
    data_idx   = fill_wr ? {set_r, fill_idx} : {set_r, word_r};
    data_be    = fill_wr ? 2'b11 : bsel_r;
    data_wdata = fill_wr ? data_from_sdram : wdata_r;
    dwe        = '0;
    for (int w = 0; w < WAYS; w++)
      dwe[w] = (fill_wr && victim_r == PTR_W'(w)) ||
               (lookup_go && !rw_r && hit_any && hit_way == PTR_W'(w));
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    nway_cache_way #(.TAG_W(TAG_W), .SET_BITS(SET_BITS), .BURST_LOG2(BURST_LOG2)) u_way (
      .clk        (clk),
      .rd_idx     ({set_r, word_r}),
      .wr_idx     (data_idx),
      .tag_we     (fill_last && victim_r == PTR_W'(g)),
      .tag_wdata  (tag_r),
      .data_we    (dwe[g]),
      .data_be    (data_be),
      .data_wdata (data_wdata),
      .rd_tag     (way_tag[g]),
      .rd_data    (way_data[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_INIT;
      init_cnt      <= '0;
      busy          <= 1'b1;
      cpu_ack       <= 1'b0;
      sdram_req     <= 1'b0;
      sdram_rw      <= 1'b1;
      data_to_cpu   <= '0;
      sdram_addr    <= '0;
      sdram_bytesel <= '0;
      data_to_sdram <= '0;
      flush_pend    <= 1'b0;
      fill_on       <= 1'b0;
      fill_cnt      <= '0;
      look_ph       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      if (flush && state != S_IDLE) flush_pend <= 1'b1;
      case (state)
        S_INIT: begin
          valid[init_cnt]  <= '0;
          rr_ptr[init_cnt] <= '0;
          init_cnt         <= init_cnt + 1'b1;
          if (&init_cnt) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (flush || flush_pend) begin
            flush_pend <= 1'b0;
            init_cnt   <= '0;
            busy       <= 1'b1;
            state      <= S_INIT;
          end else if (cpu_req) begin
            addr_r  <= cpu_addr[ADDR_WIDTH-1:1];
            rw_r    <= cpu_rw;
            bsel_r  <= cpu_bytesel;
            wdata_r <= data_from_cpu;
            look_ph <= 1'b0;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          // First cycle only presents the set index to the way RAMs.
          look_ph <= ~look_ph;
          if (look_ph) begin
            if (rw_r && hit_any) begin
              data_to_cpu <= way_data[hit_way];
              cpu_ack     <= 1'b1;
              state       <= S_RELEASE;
            end else if (rw_r) begin
              victim_r <= victim;
              if (!inv_any)
                rr_ptr[set_r] <= (rr_ptr[set_r] == PTR_W'(WAYS - 1)) ? '0 : rr_ptr[set_r] + 1'b1;
              sdram_addr <= {addr_r[ADDR_WIDTH-1:BURST_LOG2+1], {(BURST_LOG2 + 1){1'b0}}};
              sdram_rw   <= 1'b1;
              sdram_req  <= 1'b1;
              fill_on    <= 1'b0;
              state      <= S_FILL;
            end else begin
              sdram_addr    <= {addr_r, 1'b0};
              sdram_rw      <= 1'b0;
              sdram_bytesel <= bsel_r;
              data_to_sdram <= wdata_r;
              sdram_req     <= 1'b1;
              state         <= S_WRITE;
            end
          end
        end
        S_FILL: begin
          if (fill_wr && fill_idx == word_r) cap <= data_from_sdram;
          if (!fill_on) begin
            if (sdram_fill) begin
              sdram_req <= 1'b0;
              fill_on   <= 1'b1;
              fill_cnt  <= {{BURST_LOG2{1'b0}}, 1'b1};
            end
          end else if (fill_cnt != FILL_END) begin
            fill_cnt <= fill_cnt + 1'b1;
          end else begin
            fill_on                 <= 1'b0;
            valid[set_r][victim_r]  <= 1'b1;
            data_to_cpu             <= cap;
            cpu_ack                 <= 1'b1;
            state                   <= S_RELEASE;
          end
        end
        S_WRITE: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            cpu_ack   <= 1'b1;
            state     <= S_RELEASE;
          end
        end
        S_RELEASE: if (!cpu_req) state <= S_IDLE;
        default:   state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_nway_cache.sv
// Directed bench for nway_cache: SDRAM backing-store model, read-data scoreboard,
// bounded waits on every DUT handshake.

module tb_nway_cache;
  logic        clk;
  logic        reset;
  logic [25:0] cpu_addr;
  logic        cpu_req, cpu_rw;
  logic [1:0]  cpu_bytesel;
  logic [15:0] data_from_cpu;
  logic        cpu_ack;
  logic [15:0] data_to_cpu;
  logic        flush, busy;
  logic [25:0] sdram_addr;
  logic        sdram_req, sdram_rw;
  logic [1:0]  sdram_bytesel;
  logic [15:0] data_to_sdram, data_from_sdram;
  logic        sdram_fill, sdram_ack;

  int vectors, errs;
  logic [15:0] exp_q[$];
  logic [15:0] sdmem [logic [25:0]];

  nway_cache dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_bytesel(cpu_bytesel), .data_from_cpu(data_from_cpu), .cpu_ack(cpu_ack),
    .data_to_cpu(data_to_cpu), .flush(flush), .busy(busy), .sdram_addr(sdram_addr),
    .sdram_req(sdram_req), .sdram_rw(sdram_rw), .sdram_bytesel(sdram_bytesel),
    .data_to_sdram(data_to_sdram), .data_from_sdram(data_from_sdram),
    .sdram_fill(sdram_fill), .sdram_ack(sdram_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sd_word(input logic [25:0] a);
    logic [25:0] k;
    k = {a[25:1], 1'b0};
    if (sdmem.exists(k)) return sdmem[k];
    return k[16:1] ^ 16'hC3A5;
  endfunction

  function automatic logic [25:0] line_of(input logic [25:0] a);
    return {a[25:3], 3'b000};
  endfunction

  task automatic sd_burst(input logic [25:0] la, input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sdram_fill      = (i == 0);
      data_from_sdram = sd_word(la + 26'(2 * i));
      if (i == 1) check({tag, "_reqdrop"}, 32'(sdram_req), 32'd0);
    end
    @(negedge clk);
    sdram_fill      = 1'b0;
    data_from_sdram = '0;
  endtask

  task automatic do_read(input logic [25:0] a, input bit exp_miss, input bit pf, input string tag);
    bit got, missed;
    int lat;
    logic [15:0] e;
    @(negedge clk);
    cpu_addr = a; cpu_rw = 1'b1; cpu_bytesel = 2'b11; cpu_req = 1'b1;
    exp_q.push_back(sd_word(a));
    got = 0; missed = 0; lat = 0;
    for (int n = 1; n <= 80 && !got; n++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin
        got = 1;
        lat = n - 1;
      end else if (sdram_req && !missed) begin
        missed = 1;
        check({tag, "_sdaddr"}, 32'(sdram_addr), 32'(line_of(a)));
        check({tag, "_sdrw"}, 32'(sdram_rw), 32'd1);
        if (pf) begin
          @(negedge clk); flush = 1'b1;
          @(negedge clk); flush = 1'b0;
        end
        sd_burst(line_of(a), tag);
      end
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    check({tag, "_miss"}, 32'(missed), 32'(exp_miss));
    if (!exp_miss) check({tag, "_latency"}, 32'(lat), 32'd2);
    e = exp_q.pop_front();
    if (got) check({tag, "_data"}, 32'(data_to_cpu), 32'(e));
    @(negedge clk); cpu_req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ackpulse"}, 32'(cpu_ack), 32'd0);
  endtask

  task automatic do_write(input logic [25:0] a, input logic [15:0] d, input logic [1:0] bs,
                          input string tag);
    bit got, seen;
    logic [15:0] old;
    logic [25:0] k;
    @(negedge clk);
    cpu_addr = a; cpu_rw = 1'b0; cpu_bytesel = bs; data_from_cpu = d; cpu_req = 1'b1;
    got = 0; seen = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge clk); #1;
      if (cpu_ack) got = 1;
      else if (sdram_req && !seen) begin
        seen = 1;
        check({tag, "_sdrw"}, 32'(sdram_rw), 32'd0);
        check({tag, "_sdaddr"}, 32'(sdram_addr), 32'({a[25:1], 1'b0}));
        check({tag, "_sdbsel"}, 32'(sdram_bytesel), 32'(bs));
        check({tag, "_sddata"}, 32'(data_to_sdram), 32'(d));
        @(negedge clk); sdram_ack = 1'b1;
        @(posedge clk); #1;
        if (cpu_ack) got = 1;
        check({tag, "_reqdrop"}, 32'(sdram_req), 32'd0);
        @(negedge clk); sdram_ack = 1'b0;
      end
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    k   = {a[25:1], 1'b0};
    old = sd_word(k);
    sdmem[k] = {bs[1] ? d[15:8] : old[15:8], bs[0] ? d[7:0] : old[7:0]};
    @(negedge clk); cpu_req = 1'b0; cpu_rw = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    check({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  initial begin
    int  cnt;
    bit  bad, seen;
    vectors = 0; errs = 0;
    reset = 1'b0; cpu_addr = '0; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_bytesel = 2'b11;
    data_from_cpu = '0; flush = 1'b0; data_from_sdram = '0; sdram_fill = 1'b0; sdram_ack = 1'b0;
    sdmem[26'h001230] = 16'h1111;
    sdmem[26'h001232] = 16'h2222;
    sdmem[26'h001234] = 16'h3333;
    sdmem[26'h001236] = 16'h4444;

    // Reset state, then the init sweep with a request pending that must be ignored.
    @(posedge clk); #1;
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_sdram_req", 32'(sdram_req), 32'd0);
    check("rst_sdram_rw", 32'(sdram_rw), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_data_to_cpu", 32'(data_to_cpu), 32'd0);
    check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
    reset = 1'b1;
    cpu_addr = 26'h001230; cpu_req = 1'b1;
    cnt = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_ack || sdram_req) bad = 1;
      if (busy) cnt++;
      else break;
    end
    cpu_req = 1'b0;
    check("init_busy_cycles", 32'(cnt), 32'd64);
    check("init_req_ignored", 32'(bad), 32'd0);

    // Miss then hit in the same line.
    do_read(26'h001230, 1, 0, "rd1230");
    do_read(26'h001236, 0, 0, "rd1236");
    do_read(26'h001232, 0, 0, "rd1232");

    // Three lines into set 0 of a two-way cache: round-robin eviction.
    do_read(26'h000000, 1, 0, "ev0_a");
    do_read(26'h000200, 1, 0, "ev200_a");
    do_read(26'h000400, 1, 0, "ev400_a");
    do_read(26'h000200, 0, 0, "ev200_hit");
    do_read(26'h000400, 0, 0, "ev400_hit");
    do_read(26'h000000, 1, 0, "ev0_miss");
    do_read(26'h000400, 0, 0, "ev400_keep");
    do_read(26'h000200, 1, 0, "ev200_miss");
    do_read(26'h000000, 0, 0, "ev0_hit");

    // Write-through with byte merge on hits; write miss allocates nothing.
    do_write(26'h001232, 16'hABCD, 2'b01, "wr1232");
    do_read(26'h001232, 0, 0, "rd1232_merged");
    check("merge_value", 32'(sd_word(26'h001232)), 32'h000022CD);
    do_write(26'h001234, 16'h5566, 2'b10, "wr1234");
    do_read(26'h001234, 0, 0, "rd1234_merged");
    do_write(26'h003010, 16'h7777, 2'b11, "wr3010");
    do_read(26'h003010, 1, 0, "rd3010");

    // Flush arriving during a fill: fill completes, then the sweep runs.
    do_read(26'h005000, 1, 1, "fl5000");
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    check("flush_busy", 32'(seen), 32'd1);
    wait_idle("flush");
    do_read(26'h005000, 1, 0, "fl5000_re");
    do_read(26'h001236, 1, 0, "fl1236_re");

    // Reset two words into a fill, followed by stale fill/ack strobes.
    @(negedge clk);
    cpu_addr = 26'h006000; cpu_rw = 1'b1; cpu_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (sdram_req) seen = 1;
    end
    check("rf_sdreq", 32'(seen), 32'd1);
    @(negedge clk); sdram_fill = 1'b1; data_from_sdram = sd_word(26'h006000);
    @(negedge clk); sdram_fill = 1'b0; data_from_sdram = sd_word(26'h006002);
    @(negedge clk); reset = 1'b0; data_from_sdram = 16'hDEAD;
    @(posedge clk); #1;
    check("rf_sdram_req", 32'(sdram_req), 32'd0);
    check("rf_busy", 32'(busy), 32'd1);
    check("rf_data_to_cpu", 32'(data_to_cpu), 32'd0);
    @(negedge clk); reset = 1'b1; cpu_req = 1'b0; data_from_sdram = 16'hBEEF;
    @(negedge clk); sdram_fill = 1'b1; sdram_ack = 1'b1; data_from_sdram = 16'hDEAD;
    @(negedge clk); sdram_fill = 1'b0; sdram_ack = 1'b0; data_from_sdram = 16'h0000;
    wait_idle("rf");
    do_read(26'h006004, 1, 0, "rf6004");
    do_read(26'h006002, 0, 0, "rf6002_hit");
    do_read(26'h005000, 1, 0, "rf5000");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
